// File: rtl/poly_to_int_converter.sv
// Converts a redundant polynomial-coefficient result to a canonical integer below MODULUS:
// word-serial carry normalisation followed by repeated word-serial conditional subtraction.
module poly_to_int_converter #(
  parameter int unsigned WORD_BITS       = 16,
  parameter int unsigned NUM_WORDS       = 16,
  parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS =
    {1'b0, {(WORD_BITS*NUM_WORDS-1){1'b1}}} - (WORD_BITS*NUM_WORDS)'(9),
  parameter int unsigned REDUN_WORD_BITS = 1,
  parameter int unsigned I_WORD          = NUM_WORDS + 1,
  parameter int unsigned COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
  parameter int unsigned MAX_SUBS        = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_val,
  output logic                                 o_rdy,
  input  logic [I_WORD-1:0][COEF_BITS-1:0]     i_dat,
  output logic                                 o_val,
  input  logic                                 i_rdy,
  output logic [WORD_BITS*NUM_WORDS-1:0]       o_dat,
  output logic                                 o_err
);

  localparam int unsigned INT_BITS = WORD_BITS * NUM_WORDS;
  localparam int unsigned C_BITS   = REDUN_WORD_BITS + 1;
  localparam int unsigned V_WORDS  = I_WORD + 1;
  localparam int unsigned IDX_BITS = $clog2(V_WORDS);
  localparam int unsigned CNT_BITS = $clog2(MAX_SUBS + 1);
  localparam int unsigned S_BITS   = COEF_BITS + 1;
  localparam int unsigned D_BITS   = WORD_BITS + 1;

  typedef enum logic [2:0] {S_IDLE, S_CARRY, S_SUB, S_DECIDE, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [COEF_BITS-1:0]  r_coef [I_WORD];
  logic [WORD_BITS-1:0]  r_v    [V_WORDS];
  logic [WORD_BITS-1:0]  r_diff [V_WORDS];
  logic [C_BITS-1:0]     r_c;
  logic                  r_b;
  logic [IDX_BITS-1:0]   r_idx;
  logic [CNT_BITS-1:0]   r_cnt;
  logic                  r_rdy;
  logic                  r_val;
  logic                  r_err;
  logic [INT_BITS-1:0]   r_dat;

  logic [COEF_BITS-1:0]  w_coef;
  logic [WORD_BITS-1:0]  w_vk;
  logic [WORD_BITS-1:0]  w_mk;
  logic [S_BITS-1:0]     w_sum;
  logic [C_BITS-1:0]     w_c_next;
  logic [D_BITS-1:0]     w_diff;
  logic                  w_accept;
  logic                  w_last_carry;
  logic                  w_last_sub;
  logic                  w_retry;

  // Word selectors for the serial datapath (M words above NUM_WORDS read as zero)
  always_comb begin
    w_coef = '0;
    w_vk   = '0;
    w_mk   = '0;
    for (int k = 0; k < int'(I_WORD); k++)
      if (r_idx == IDX_BITS'(k)) w_coef = r_coef[k];
    for (int k = 0; k < int'(V_WORDS); k++)
      if (r_idx == IDX_BITS'(k)) w_vk = r_v[k];
    for (int k = 0; k < int'(NUM_WORDS); k++)
      if (r_idx == IDX_BITS'(k)) w_mk = MODULUS[k*WORD_BITS +: WORD_BITS];
  end

  assign w_sum        = S_BITS'(w_coef) + S_BITS'(r_c);
  assign w_c_next     = C_BITS'(w_sum >> WORD_BITS);
  assign w_diff       = D_BITS'(w_vk) - D_BITS'(w_mk) - D_BITS'(r_b);
  assign w_accept     = (r_state == S_IDLE) && i_val && r_rdy;
  assign w_last_carry = (r_idx == IDX_BITS'(I_WORD - 1));
  assign w_last_sub   = (r_idx == IDX_BITS'(I_WORD));
  assign w_retry      = (r_state == S_DECIDE) && !r_b && (r_cnt != CNT_BITS'(MAX_SUBS));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_CARRY;
      S_CARRY:  if (w_last_carry) w_next = S_SUB;
      S_SUB:    if (w_last_sub) w_next = S_DECIDE;
      S_DECIDE: w_next = w_retry ? S_SUB : S_DONE;
      S_DONE:   if (i_rdy) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Serial datapath: capture, carry propagation, subtraction, and difference commit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(I_WORD); k++) r_coef[k] <= '0;
      for (int k = 0; k < int'(V_WORDS); k++) begin
        r_v[k]    <= '0;
        r_diff[k] <= '0;
      end
      r_c   <= '0;
      r_b   <= 1'b0;
      r_idx <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          for (int k = 0; k < int'(I_WORD); k++) r_coef[k] <= i_dat[k];
          r_cnt <= '0;
          r_idx <= '0;
          r_c   <= '0;
        end
        S_CARRY: begin
          r_v[r_idx] <= w_sum[WORD_BITS-1:0];
          r_c        <= w_c_next;
          if (w_last_carry) begin
            r_v[I_WORD] <= WORD_BITS'(w_c_next);
            r_idx       <= '0;
            r_b         <= 1'b0;
          end else begin
            r_idx <= r_idx + IDX_BITS'(1);
          end
        end
        S_SUB: begin
          r_diff[r_idx] <= w_diff[WORD_BITS-1:0];
          r_b           <= w_diff[WORD_BITS];
          r_idx         <= w_last_sub ? '0 : r_idx + IDX_BITS'(1);
        end
        S_DECIDE: if (w_retry) begin
          for (int k = 0; k < int'(V_WORDS); k++) r_v[k] <= r_diff[k];
          r_cnt <= r_cnt + CNT_BITS'(1);
          r_b   <= 1'b0;
          r_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  // Registered handshake and result; result latched on entry to DONE and held there
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdy <= 1'b1;
      r_val <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_rdy <= (w_next == S_IDLE);
      r_val <= (w_next == S_DONE);
      if (r_state == S_DECIDE && w_next == S_DONE) begin
        r_err <= !r_b;
        for (int k = 0; k < int'(NUM_WORDS); k++)
          r_dat[k*WORD_BITS +: WORD_BITS] <= r_v[k];
      end
    end
  end

  assign o_rdy = r_rdy;
  assign o_val = r_val;
  assign o_err = r_err;
  assign o_dat = r_dat;

endmodule

// File: tb/tb_poly_to_int_converter.sv
// Directed bench for poly_to_int_converter: values, latency, backpressure hold and mid-run reset.
module tb_poly_to_int_converter;

  localparam int unsigned WORD_BITS = 16;
  localparam int unsigned NUM_WORDS = 16;
  localparam int unsigned I_WORD    = NUM_WORDS + 1;
  localparam int unsigned COEF_BITS = WORD_BITS + 1;
  localparam int unsigned INT_BITS  = WORD_BITS * NUM_WORDS;

  logic                             clk;
  logic                             rst_n;
  logic                             i_val;
  logic                             o_rdy;
  logic [I_WORD-1:0][COEF_BITS-1:0] i_dat;
  logic                             o_val;
  logic                             i_rdy;
  logic [INT_BITS-1:0]              o_dat;
  logic                             o_err;

  int n_tests;
  int n_fail;

  logic [I_WORD-1:0][COEF_BITS-1:0] coefs;
  logic [INT_BITS-1:0]              exp_dat;

  poly_to_int_converter dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_val   (i_val),
    .o_rdy   (o_rdy),
    .i_dat   (i_dat),
    .o_val   (o_val),
    .i_rdy   (i_rdy),
    .o_dat   (o_dat),
    .o_err   (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [INT_BITS-1:0] obs, input logic [INT_BITS-1:0] expv);
    n_tests++;
    assert (obs === expv)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
  endtask

  // One conversion: accept in cycle 0, measure cycle of first o_val, optional backpressure, handshake
  task automatic do_conv(input string tag, input logic [I_WORD-1:0][COEF_BITS-1:0] c,
                         input int exp_lat, input logic [INT_BITS-1:0] edat,
                         input logic eerr, input int hold);
    int   cyc;
    logic rdy_bad;
    check({tag, "_rdy_idle"}, INT_BITS'(o_rdy), INT_BITS'(1));
    i_dat = c;
    i_val = 1'b1;
    @(posedge clk); #1;
    i_val   = 1'b0;
    i_dat   = '0;
    cyc     = 1;
    rdy_bad = 1'b0;
    while (o_val !== 1'b1 && cyc < 300) begin
      if (o_rdy !== 1'b0) rdy_bad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, INT_BITS'(cyc), INT_BITS'(exp_lat));
    check({tag, "_dat"}, o_dat, edat);
    check({tag, "_err"}, INT_BITS'(o_err), INT_BITS'(eerr));
    check({tag, "_rdy_busy"}, INT_BITS'({rdy_bad, o_rdy}), INT_BITS'(0));
    for (int i = 0; i < hold; i++) begin
      i_val = 1'b1;
      i_dat = '1;
      @(posedge clk); #1;
      check({tag, "_hold_val"}, INT_BITS'(o_val), INT_BITS'(1));
      check({tag, "_hold_dat"}, o_dat, edat);
      check({tag, "_hold_err"}, INT_BITS'(o_err), INT_BITS'(eerr));
      check({tag, "_hold_rdy"}, INT_BITS'(o_rdy), INT_BITS'(0));
    end
    i_val = 1'b0;
    i_rdy = 1'b1;
    @(posedge clk); #1;
    i_rdy = 1'b0;
    check({tag, "_val_drop"}, INT_BITS'(o_val), INT_BITS'(0));
    check({tag, "_rdy_back"}, INT_BITS'(o_rdy), INT_BITS'(1));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    i_val   = 1'b0;
    i_rdy   = 1'b0;
    i_dat   = '0;

    // Reset values
    #12;
    check("rst_rdy", INT_BITS'(o_rdy), INT_BITS'(1));
    check("rst_val", INT_BITS'(o_val), INT_BITS'(0));
    check("rst_err", INT_BITS'(o_err), INT_BITS'(0));
    check("rst_dat", o_dat, '0);
    #11;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All zero
    coefs = '0;
    do_conv("zero", coefs, 37, '0, 1'b0, 0);

    // Carry chain: 0x1FFFF + 0x1FFFF*2^16 = 0x2_0000_FFFF
    coefs    = '0;
    coefs[0] = 17'h1FFFF;
    coefs[1] = 17'h1FFFF;
    exp_dat  = INT_BITS'(64'h2_0000_FFFF);
    do_conv("carry", coefs, 37, exp_dat, 1'b0, 0);

    // Exactly MODULUS: one subtraction to zero
    coefs = '0;
    coefs[0] = 17'h0FFF6;
    for (int k = 1; k < 15; k++) coefs[k] = 17'h0FFFF;
    coefs[15] = 17'h07FFF;
    do_conv("modulus", coefs, 56, '0, 1'b0, 0);

    // 2^256 = 2*MODULUS + 20
    coefs     = '0;
    coefs[16] = 17'h00001;
    do_conv("pow256", coefs, 75, INT_BITS'(20), 1'b0, 0);

    // All 0x1FFFF: V words FFFF,0,1..1,top 2; low 256 bits of V - 4M = V_low + 40
    for (int k = 0; k < int'(I_WORD); k++) coefs[k] = 17'h1FFFF;
    exp_dat = {{15{16'h0001}}, 16'h0027};
    do_conv("overflow", coefs, 113, exp_dat, 1'b1, 10);

    // Reset while in SUB of the MODULUS case
    coefs = '0;
    coefs[0] = 17'h0FFF6;
    for (int k = 1; k < 15; k++) coefs[k] = 17'h0FFFF;
    coefs[15] = 17'h07FFF;
    i_dat = coefs;
    i_val = 1'b1;
    @(posedge clk); #1;
    i_val = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("midrst_val", INT_BITS'(o_val), INT_BITS'(0));
    check("midrst_rdy", INT_BITS'(o_rdy), INT_BITS'(1));
    check("midrst_err", INT_BITS'(o_err), INT_BITS'(0));
    check("midrst_dat", o_dat, '0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle_val", INT_BITS'(o_val), INT_BITS'(0));
    coefs = '0;
    do_conv("after_rst", coefs, 37, '0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
